ysyx_23060201_ifu: RTL and testbench

Instruction fetch stage, directly upstream of the decode stage. Holds the PC, issues one word-aligned fetch request at a time to instruction memory, and buffers the returned 32-bit instruction. Hands the instruction and its PC to decode over a valid/ready handshake. Accepts PC redirects from execute (branch, jal, jalr, trap) and discards any fetch in flight when a redirect arrives.

---
 rtl/ysyx_23060201_ifu_if.sv | 30 +++
 rtl/ysyx_23060201_ifu.sv | 129 ++++++++++++
 tb/tb_ysyx_23060201_ifu.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060201_ifu_if.sv
// Fetch-stage bundle: instruction-memory request/response, the decode handshake
// and the execute redirect. The master side is the fetch unit.
interface ysyx_23060201_ifu_if #(
   parameter int unsigned XLEN = 32
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_resp_valid;
   logic [XLEN-1:0] imem_resp_data;
   logic            inst_valid;
   logic            inst_ready;
   logic [XLEN-1:0] inst;
   logic [XLEN-1:0] inst_pc;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            fetch_busy;

   modport master (
      output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_busy,
      input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
             redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_busy,
      output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
             redirect_valid, redirect_pc
   );
endinterface

// File: rtl/ysyx_23060201_ifu.sv
// Instruction fetch: one outstanding word fetch at a time, a single-entry
// instruction buffer toward decode, and redirects that squash any fetch in flight.
module ysyx_23060201_ifu #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic                clk,
   input  logic                rst_n,
   ysyx_23060201_ifu_if.master bus
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } state_e;

   localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] inst_q, inst_d;
   logic [XLEN-1:0] inst_pc_q, inst_pc_d;
   logic            inst_valid_q, inst_valid_d;
   logic            req_valid_q, req_valid_d;
   logic            busy_q, busy_d;

   logic            req_fire;
   logic [XLEN-1:0] redirect_target;

   assign req_fire        = req_valid_q & bus.imem_req_ready;
   assign redirect_target = {bus.redirect_pc[XLEN-1:2], 2'b00};

   // Next-state decode; a redirect outranks every other event in its cycle.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_valid_d = inst_valid_q;
      case (state_q)
         S_REQ: begin
            if (bus.redirect_valid) begin
               pc_d = redirect_target;
               // A request accepted this cycle carried the old pc; its data must be squashed.
               state_d = req_fire ? S_DROP : S_REQ;
            end else if (req_fire) begin
               state_d = S_WAIT;
            end else begin
               state_d = S_REQ;
            end
         end
         S_WAIT: begin
            if (bus.redirect_valid) begin
               pc_d    = redirect_target;
               state_d = bus.imem_resp_valid ? S_REQ : S_DROP;
            end else if (bus.imem_resp_valid) begin
               inst_d       = bus.imem_resp_data;
               inst_pc_d    = pc_q;
               inst_valid_d = 1'b1;
               state_d      = S_HOLD;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_HOLD: begin
            if (bus.redirect_valid) begin
               pc_d         = redirect_target;
               inst_valid_d = 1'b0;
               state_d      = S_REQ;
            end else if (bus.inst_ready) begin
               pc_d         = pc_q + PC_STEP;
               inst_valid_d = 1'b0;
               state_d      = S_REQ;
            end else begin
               state_d = S_HOLD;
            end
         end
         S_DROP: begin
            if (bus.redirect_valid) begin
               pc_d = redirect_target;
            end else begin
               pc_d = pc_q;
            end
            if (bus.imem_resp_valid) begin
               state_d = S_REQ;
            end else begin
               state_d = S_DROP;
            end
         end
         default: begin
            inst_valid_d = 1'b0;
            state_d      = S_REQ;
         end
      endcase
      req_valid_d = (state_d == S_REQ);
      busy_d      = (state_d == S_WAIT) || (state_d == S_DROP);
   end

   // Fetch state, pc, instruction buffer and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         inst_q       <= {XLEN{1'b0}};
         inst_pc_q    <= {XLEN{1'b0}};
         inst_valid_q <= 1'b0;
         req_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         inst_valid_q <= inst_valid_d;
         req_valid_q  <= req_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.imem_req_valid = req_valid_q;
   assign bus.imem_req_addr  = pc_q;
   assign bus.inst_valid     = inst_valid_q;
   assign bus.inst           = inst_q;
   assign bus.inst_pc        = inst_pc_q;
   assign bus.fetch_busy     = busy_q;

endmodule

// File: tb/tb_ysyx_23060201_ifu.sv
// Directed bench for the fetch unit: memory and decode are driven cycle by cycle.
module tb_ysyx_23060201_ifu;

   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;

   ysyx_23060201_ifu_if #(.XLEN(32)) bus ();

   ysyx_23060201_ifu #(
      .XLEN     (32),
      .RESET_PC (32'h8000_0000)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      tick();
      tick();
      tests_run++; if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_req_valid: got %b want 0", bus.imem_req_valid); end
      tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_inst_valid: got %b want 0", bus.inst_valid); end
      tests_run++; if (bus.inst !== 32'h0) begin tests_failed++; $display("FAIL rst_inst: got %h want 0", bus.inst); end
      tests_run++; if (bus.inst_pc !== 32'h0) begin tests_failed++; $display("FAIL rst_inst_pc: got %h want 0", bus.inst_pc); end
      tests_run++; if (bus.fetch_busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b want 0", bus.fetch_busy); end
      tests_run++; if (bus.imem_req_addr !== 32'h8000_0000) begin tests_failed++; $display("FAIL rst_addr: got %h want 80000000", bus.imem_req_addr); end
      rst_n = 1'b1;
      tick();
      tests_run++; if (bus.imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL first_req_valid: got %b want 1", bus.imem_req_valid); end
      tests_run++; if (bus.imem_req_addr !== 32'h8000_0000) begin tests_failed++; $display("FAIL first_req_addr: got %h want 80000000", bus.imem_req_addr); end
   endtask

   task automatic test_basic_fetch();
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      tests_run++; if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_wait_req: got %b want 0", bus.imem_req_valid); end
      tests_run++; if (bus.fetch_busy !== 1'b1) begin tests_failed++; $display("FAIL basic_busy: got %b want 1", bus.fetch_busy); end
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = 32'h0000_0413;
      #1;
      tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_no_comb_valid: got %b want 0", bus.inst_valid); end
      tick();
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
      tests_run++; if (bus.inst_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_inst_valid: got %b want 1", bus.inst_valid); end
      tests_run++; if (bus.inst !== 32'h0000_0413) begin tests_failed++; $display("FAIL basic_inst: got %h want 00000413", bus.inst); end
      tests_run++; if (bus.inst_pc !== 32'h8000_0000) begin tests_failed++; $display("FAIL basic_inst_pc: got %h want 80000000", bus.inst_pc); end
      tests_run++; if (bus.fetch_busy !== 1'b0) begin tests_failed++; $display("FAIL basic_hold_busy: got %b want 0", bus.fetch_busy); end
      bus.inst_ready = 1'b1;
      tick();
      bus.inst_ready = 1'b0;
      tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_valid_drop: got %b want 0", bus.inst_valid); end
      tests_run++; if (bus.imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_next_req: got %b want 1", bus.imem_req_valid); end
      tests_run++; if (bus.imem_req_addr !== 32'h8000_0004) begin tests_failed++; $display("FAIL basic_next_addr: got %h want 80000004", bus.imem_req_addr); end
   endtask

   task automatic test_req_stall();
      for (int i = 0; i < 3; i++) begin
         tick();
         tests_run++; if (bus.imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_req_valid[%0d]: got %b want 1", i, bus.imem_req_valid); end
         tests_run++; if (bus.imem_req_addr !== 32'h8000_0004) begin tests_failed++; $display("FAIL stall_req_addr[%0d]: got %h want 80000004", i, bus.imem_req_addr); end
      end
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      tests_run++; if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_accept: got %b want 0", bus.imem_req_valid); end
   endtask

   task automatic test_decode_stall();
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = 32'h0010_0093;
      tick();
      bus.imem_resp_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tests_run++; if (bus.inst_valid !== 1'b1) begin tests_failed++; $display("FAIL dstall_valid[%0d]: got %b want 1", i, bus.inst_valid); end
         tests_run++; if (bus.inst !== 32'h0010_0093) begin tests_failed++; $display("FAIL dstall_inst[%0d]: got %h want 00100093", i, bus.inst); end
         tests_run++; if (bus.inst_pc !== 32'h8000_0004) begin tests_failed++; $display("FAIL dstall_pc[%0d]: got %h want 80000004", i, bus.inst_pc); end
         tests_run++; if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL dstall_no_req[%0d]: got %b want 0", i, bus.imem_req_valid); end
         tick();
      end
      bus.inst_ready = 1'b1;
      tick();
      bus.inst_ready = 1'b0;
      tests_run++; if (bus.imem_req_addr !== 32'h8000_0008) begin tests_failed++; $display("FAIL dstall_next_addr: got %h want 80000008", bus.imem_req_addr); end
      tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL dstall_valid_drop: got %b want 0", bus.inst_valid); end
   endtask

   task automatic test_redirect_wait();
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      tick();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h8000_1003;
      tick();
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      tests_run++; if (bus.fetch_busy !== 1'b1) begin tests_failed++; $display("FAIL rwait_drop_busy: got %b want 1", bus.fetch_busy); end
      tests_run++; if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL rwait_no_req: got %b want 0", bus.imem_req_valid); end
      tick();
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = 32'hDEAD_BEEF;
      tick();
      bus.imem_resp_valid = 1'b0;
      tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rwait_dropped: got %b want 0", bus.inst_valid); end
      tests_run++; if (bus.imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL rwait_req: got %b want 1", bus.imem_req_valid); end
      tests_run++; if (bus.imem_req_addr !== 32'h8000_1000) begin tests_failed++; $display("FAIL rwait_addr: got %h want 80001000", bus.imem_req_addr); end
      tests_run++; if (bus.fetch_busy !== 1'b0) begin tests_failed++; $display("FAIL rwait_busy_clear: got %b want 0", bus.fetch_busy); end
   endtask

   task automatic test_redirect_hold();
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready  = 1'b0;
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = 32'h0000_0013;
      tick();
      bus.imem_resp_valid = 1'b0;
      tests_run++; if (bus.inst_pc !== 32'h8000_1000) begin tests_failed++; $display("FAIL rhold_inst_pc: got %h want 80001000", bus.inst_pc); end
      bus.inst_ready     = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h8000_2000;
      tick();
      bus.inst_ready     = 1'b0;
      bus.redirect_valid = 1'b0;
      tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rhold_valid: got %b want 0", bus.inst_valid); end
      tests_run++; if (bus.imem_req_addr !== 32'h8000_2000) begin tests_failed++; $display("FAIL rhold_addr: got %h want 80002000", bus.imem_req_addr); end
   endtask

   task automatic test_redirect_req();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h8000_3006;
      tick();
      tests_run++; if (bus.imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL rreq_valid: got %b want 1", bus.imem_req_valid); end
      tests_run++; if (bus.imem_req_addr !== 32'h8000_3004) begin tests_failed++; $display("FAIL rreq_addr: got %h want 80003004", bus.imem_req_addr); end
      bus.redirect_pc    = 32'hFFFF_FFFF;
      bus.imem_req_ready = 1'b1;
      tick();
      bus.redirect_valid = 1'b0;
      bus.imem_req_ready = 1'b0;
      tests_run++; if (bus.fetch_busy !== 1'b1) begin tests_failed++; $display("FAIL rreq_drop_busy: got %b want 1", bus.fetch_busy); end
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = 32'h0BAD_0BAD;
      tick();
      bus.imem_resp_valid = 1'b0;
      tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rreq_dropped: got %b want 0", bus.inst_valid); end
      tests_run++; if (bus.imem_req_addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL rreq_new_addr: got %h want fffffffc", bus.imem_req_addr); end
   endtask

   task automatic test_wrap();
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready  = 1'b0;
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = 32'h1234_5678;
      tick();
      bus.imem_resp_valid = 1'b0;
      tests_run++; if (bus.inst_pc !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_inst_pc: got %h want fffffffc", bus.inst_pc); end
      bus.inst_ready = 1'b1;
      tick();
      bus.inst_ready = 1'b0;
      tests_run++; if (bus.imem_req_addr !== 32'h0000_0000) begin tests_failed++; $display("FAIL wrap_addr: got %h want 00000000", bus.imem_req_addr); end
   endtask

   task automatic test_reset_midflight();
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      tests_run++; if (bus.fetch_busy !== 1'b0) begin tests_failed++; $display("FAIL mrst_busy: got %b want 0", bus.fetch_busy); end
      tests_run++; if (bus.inst !== 32'h0) begin tests_failed++; $display("FAIL mrst_inst: got %h want 0", bus.inst); end
      tests_run++; if (bus.inst_pc !== 32'h0) begin tests_failed++; $display("FAIL mrst_inst_pc: got %h want 0", bus.inst_pc); end
      tests_run++; if (bus.imem_req_addr !== 32'h8000_0000) begin tests_failed++; $display("FAIL mrst_addr: got %h want 80000000", bus.imem_req_addr); end
      tick();
      rst_n = 1'b1;
      tick();
      tests_run++; if (bus.imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL mrst_req_valid: got %b want 1", bus.imem_req_valid); end
      tests_run++; if (bus.imem_req_addr !== 32'h8000_0000) begin tests_failed++; $display("FAIL mrst_req_addr: got %h want 80000000", bus.imem_req_addr); end
   endtask

   initial begin
      tests_run           = 0;
      tests_failed        = 0;
      rst_n               = 1'b0;
      bus.imem_req_ready  = 1'b0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
      bus.inst_ready      = 1'b0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_pc     = 32'h0;
      test_reset();
      test_basic_fetch();
      test_req_stall();
      test_decode_stall();
      test_redirect_wait();
      test_redirect_hold();
      test_redirect_req();
      test_wrap();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
